// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and defaults for the MEM-stage SRAM controller
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int DEF_ACCESS_CYCLES = 2;
endpackage

// File: rtl/arm_sram_controller.sv
// arm_sram_controller: word requests from the MEM stage performed as two half-word async SRAM accesses
module arm_sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  state_t state, state_n;
  logic [2:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic [16:0] word_off;
  logic is_wr, req, last, act;
  assign req = wr_en | rd_en;
  assign last = cnt == 3'(ACCESS_CYCLES - 1);
  assign act = state == LOW || state == HIGH;
  assign word_off = 17'((addr_q - BASE_ADDR) >> 2);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = req ? LOW : IDLE;
      LOW:  state_n = last ? HIGH : LOW;
      HIGH: state_n = last ? DONE : HIGH;
      default: state_n = IDLE;
    endcase
  end
  assign ready = state == IDLE ? !req : state == DONE;
  assign sram_addr = act ? {word_off, state == HIGH} : '0;
  assign sram_dq_out = act && is_wr ? (state == HIGH ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign sram_dq_oe = act && is_wr;
  assign sram_we_n = !(act && is_wr);
  assign sram_oe_n = !(act && !is_wr);
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      read_data <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      is_wr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= act && !last ? cnt + 3'd1 : 3'd0;
      if (state == IDLE && req) begin
        addr_q <= address;
        wdata_q <= write_data;
        is_wr <= wr_en;
      end
      // each half is sampled on the final cycle of its access window
      if (act && last && !is_wr) begin
        if (state == LOW) read_data[15:0] <= sram_dq_in;
        else read_data[31:16] <= sram_dq_in;
      end
    end
  end
endmodule
